pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 14 +
 rtl/pipe_hazard_ctrl_sat_counter.sv | 20 ++
 rtl/pipe_hazard_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the control FSM state encoding and register-file constants.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FREEZE     = 2'd1,
    FETCH_WAIT = 2'd2
  } hz_state_t;

  localparam int CNT_W_DEF = 16;
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush statistics.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for a 5-stage pipeline: load-use, branch
// redirect, instruction-fetch wait and data-memory freeze handling.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             br_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             ifid_bubble,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  hz_state_t state, nxt;
  logic      br_pend, pend_nxt;
  logic      lu, eff_br, flush;

  assign lu = ex_memread && (ex_rd != REG_ZERO) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) ||
               (id_use_rs2 && (id_rs2 == ex_rd)));

  assign eff_br = br_taken || br_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      br_pend <= 1'b0;
    end else begin
      state   <= nxt;
      br_pend <= pend_nxt;
    end
  end

  // Once dmem is ready, RUN and FETCH_WAIT (and a FREEZE exit)
  // share the same priority: branch, load-use, fetch wait, normal.
  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    idex_we     = 1'b0;
    ifid_bubble = 1'b0;
    idex_bubble = 1'b0;
    flush       = 1'b0;
    nxt         = state;
    pend_nxt    = br_pend;
    if (rst) begin
      ifid_bubble = 1'b1;
      idex_bubble = 1'b1;
      nxt         = RUN;
      pend_nxt    = 1'b0;
    end else if (!dmem_ready) begin
      nxt = FREEZE;
      if ((state == FREEZE) && br_taken) begin
        pend_nxt = 1'b1;
      end
    end else begin
      nxt      = RUN;
      pend_nxt = 1'b0;
      if (eff_br) begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_we     = 1'b1;
        ifid_bubble = 1'b1;
        idex_bubble = 1'b1;
        flush       = 1'b1;
      end else if (lu) begin
        idex_we     = 1'b1;
        idex_bubble = 1'b1;
      end else if (!imem_ready) begin
        ifid_we     = 1'b1;
        ifid_bubble = 1'b1;
        idex_we     = 1'b1;
        nxt         = FETCH_WAIT;
      end else begin
        pc_we   = 1'b1;
        ifid_we = 1'b1;
        idex_we = 1'b1;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall (
    .clk   (clk),
    .rst   (rst),
    .inc   (!rst && !pc_we),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush),
    .count (flush_count)
  );

endmodule
